// File: rtl/pkt_frame_builder_if.sv
// AXI4-Stream beat bundle between the frame builder and the MAC/TX datapath.
interface pkt_frame_builder_if #(
  parameter int DATA_WIDTH = 64
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/pkt_frame_builder.sv
// Turns {five-tuple, len} descriptors from a fall-through FIFO into Ethernet/IPv4/L4 frames
// on AXI4-Stream. Define PKT_IP_CSUM_EN to fill in the IPv4 header checksum.
module pkt_frame_builder #(
  parameter int          PKT_TUPLE_WIDTH = 104,
  parameter int          DATA_WIDTH      = 64,
  parameter int          MIN_LEN         = 60,
  parameter int          MAX_LEN         = 1514,
  parameter int          IFG_CYCLES      = 2,
  parameter logic [47:0] DST_MAC         = 48'h0000_0000_0002,
  parameter logic [47:0] SRC_MAC         = 48'h0000_0000_0001
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        gen_en,
  input  logic [PKT_TUPLE_WIDTH+15:0] fifo_data_in,
  input  logic                        fifo_empty,
  output logic                        fifo_rd_en,
  pkt_frame_builder_if.master         m_axis,
  output logic [31:0]                 pkt_count,
  output logic [47:0]                 byte_count
);
  localparam int NB        = DATA_WIDTH / 8;
  localparam int HDR_BYTES = 42;

  typedef enum logic [1:0] {IDLE, LOAD, SEND, GAP} state_t;
  state_t state_reg, state_next;

  logic [PKT_TUPLE_WIDTH-1:0] tuple_reg;
  logic [15:0]                len_reg, words_reg, beat_reg, gap_reg;
  logic [NB-1:0]              last_keep_reg;
  logic [HDR_BYTES*8-1:0]     hdr_reg, hdr_next;
  logic [31:0]                pkt_count_reg;
  logic [47:0]                byte_count_reg;
  logic [15:0]                desc_len, clamp_len;
  logic                       beat_fire, last_beat;

  logic [31:0] src_ip, dst_ip;
  logic [15:0] sport, dport, tot_len, l4_len, ip_csum;
  logic [7:0]  proto;

  assign src_ip  = tuple_reg[103:72];
  assign dst_ip  = tuple_reg[71:40];
  assign sport   = tuple_reg[39:24];
  assign dport   = tuple_reg[23:8];
  assign proto   = tuple_reg[7:0];
  assign tot_len = len_reg - 16'd14;
  assign l4_len  = len_reg - 16'd34;

`ifdef PKT_IP_CSUM_EN
  // Ten header words summed wide, then end-around carry folded back in.
  logic [19:0] csum_sum;
  logic [16:0] csum_fold;
  assign csum_sum  = 20'h04500 + 20'(tot_len) + 20'(pkt_count_reg[15:0]) + 20'h04000
                   + 20'({8'h40, proto}) + 20'(src_ip[31:16]) + 20'(src_ip[15:0])
                   + 20'(dst_ip[31:16]) + 20'(dst_ip[15:0]);
  assign csum_fold = 17'(csum_sum[15:0]) + 17'(csum_sum[19:16]);
  assign ip_csum   = ~(csum_fold[15:0] + 16'(csum_fold[16]));
`else
  assign ip_csum = 16'h0000;
`endif

  // Byte 0 sits in the MSBs so multi-byte fields read naturally big-endian.
  assign hdr_next = {DST_MAC, SRC_MAC, 16'h0800, 8'h45, 8'h00, tot_len, pkt_count_reg[15:0],
                     16'h4000, 8'h40, proto, ip_csum, src_ip, dst_ip, sport, dport, l4_len,
                     16'h0000};

  always_comb begin
    desc_len = fifo_data_in[15:0];
    if (desc_len < 16'(MIN_LEN))
      clamp_len = 16'(MIN_LEN);
    else if (desc_len > 16'(MAX_LEN))
      clamp_len = 16'(MAX_LEN);
    else
      clamp_len = desc_len;
  end

  logic [7:0] hdr_bytes [64];
  for (genvar gi = 0; gi < 64; gi++) begin : g_hdr
    if (gi < HDR_BYTES) begin : g_byte
      assign hdr_bytes[gi] = hdr_reg[(HDR_BYTES-1-gi)*8 +: 8];
    end else begin : g_zero
      assign hdr_bytes[gi] = 8'h00;
    end
  end

  logic [15:0]           beat_base;
  logic [DATA_WIDTH-1:0] beat_data;
  assign beat_base = {beat_reg[12:0], 3'b000};

  for (genvar gi = 0; gi < NB; gi++) begin : g_lane
    logic [15:0] off;
    logic [7:0]  lane;
    assign off = beat_base + 16'(gi);
    always_comb begin
      lane = 8'h00;
      if (off < 16'(HDR_BYTES))
        lane = hdr_bytes[off[5:0]];
      else if (off < len_reg)
        lane = off[7:0];
    end
    assign beat_data[8*gi +: 8] = lane;
  end

  assign last_beat     = (beat_reg == words_reg - 16'd1);
  assign beat_fire     = (state_reg == SEND) && m_axis.tready;
  assign m_axis.tvalid = (state_reg == SEND);
  assign m_axis.tlast  = (state_reg == SEND) && last_beat;
  assign m_axis.tkeep  = (state_reg != SEND) ? '0 : (last_beat ? last_keep_reg : '1);
  assign m_axis.tdata  = (state_reg == SEND) ? beat_data : '0;
  assign pkt_count     = pkt_count_reg;
  assign byte_count    = byte_count_reg;

  always_comb begin
    state_next = state_reg;
    fifo_rd_en = 1'b0;
    case (state_reg)
      IDLE: begin
        if (gen_en && !fifo_empty && !reset) begin
          fifo_rd_en = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: state_next = SEND;
      SEND: begin
        if (beat_fire && last_beat)
          state_next = (IFG_CYCLES == 0) ? IDLE : GAP;
      end
      GAP: begin
        if (gap_reg == 16'(IFG_CYCLES - 1))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg      <= IDLE;
      beat_reg       <= '0;
      gap_reg        <= '0;
      pkt_count_reg  <= '0;
      byte_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == LOAD)
        beat_reg <= '0;
      else if (beat_fire)
        beat_reg <= last_beat ? 16'd0 : beat_reg + 16'd1;
      if (beat_fire && last_beat) begin
        pkt_count_reg  <= pkt_count_reg + 32'd1;
        byte_count_reg <= byte_count_reg + 48'(len_reg);
      end
      gap_reg <= (state_reg == GAP) ? gap_reg + 16'd1 : 16'd0;
    end
  end

  // Datapath registers need no reset: they are only observed in SEND, after a LOAD.
  always_ff @(posedge clk) begin
    if (fifo_rd_en) begin
      tuple_reg <= fifo_data_in[PKT_TUPLE_WIDTH+15:16];
      len_reg   <= clamp_len;
    end
    if (state_reg == LOAD) begin
      hdr_reg       <= hdr_next;
      words_reg     <= (len_reg + 16'd7) >> 3;
      last_keep_reg <= (len_reg[2:0] == 3'd0) ? '1 : NB'((9'h001 << len_reg[2:0]) - 9'h001);
    end
  end
endmodule

// File: tb/tb_pkt_frame_builder.sv
// Bench for pkt_frame_builder: FIFO model, beat monitor and frame scoreboard built from the
// frame layout rules, driven by a directed table, hand sequences and random backpressure.
`timescale 1ns/1ps
module tb_pkt_frame_builder;
  localparam int IFG = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         gen_en = 1'b0;
  logic [119:0] fifo_data_in = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_rd_en;
  logic [31:0]  pkt_count;
  logic [47:0]  byte_count;

  pkt_frame_builder_if axis();

  pkt_frame_builder dut (
    .clk(clk), .reset(reset), .gen_en(gen_en), .fifo_data_in(fifo_data_in),
    .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en), .m_axis(axis),
    .pkt_count(pkt_count), .byte_count(byte_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- descriptor FIFO model (fall-through) ----------------
  logic [119:0] desc_q[$];
  logic [119:0] sb_q[$];
  int rd_cyc_q[$];
  int pops = 0;
  logic pop_pending = 1'b0;

  task automatic refresh_fifo();
    fifo_empty   = (desc_q.size() == 0);
    fifo_data_in = fifo_empty ? '0 : desc_q[0];
  endtask

  task automatic push_desc(input logic [103:0] t, input logic [15:0] l);
    desc_q.push_back({t, l});
    refresh_fifo();
  endtask

  function automatic logic [103:0] rand_tuple();
    return {$urandom(), $urandom(), $urandom(), 8'($urandom())};
  endfunction

  always @(negedge clk) begin
    if (fifo_rd_en) begin
      sb_q.push_back(fifo_data_in);
      rd_cyc_q.push_back(cyc);
      pops++;
      pop_pending = 1'b1;
    end
  end

  always @(posedge clk) begin
    if (pop_pending) begin
      #1;
      pop_pending = 1'b0;
      if (desc_q.size() > 0) void'(desc_q.pop_front());
      refresh_fifo();
    end
  end

  // ---------------- reference frame model ----------------
  logic [7:0]  exp_frame [0:1513];
  logic [7:0]  got_frame [0:1513];
  logic [47:0] dst_mac = 48'h0000_0000_0002;
  logic [47:0] src_mac = 48'h0000_0000_0001;

  task automatic put16(input int at, input logic [15:0] v);
    exp_frame[at]   = v[15:8];
    exp_frame[at+1] = v[7:0];
  endtask

  task automatic build_expected(input logic [119:0] d, input logic [15:0] id, output int clen);
    logic [103:0] t;
    int l;
`ifdef PKT_IP_CSUM_EN
    logic [31:0] sum;
`endif
    t = d[119:16];
    l = int'(d[15:0]);
    clen = (l < 60) ? 60 : ((l > 1514) ? 1514 : l);
    for (int i = 0; i < 6; i++) begin
      exp_frame[i]   = 8'(dst_mac >> (40 - 8*i));
      exp_frame[6+i] = 8'(src_mac >> (40 - 8*i));
    end
    put16(12, 16'h0800);
    exp_frame[14] = 8'h45;
    exp_frame[15] = 8'h00;
    put16(16, 16'(clen - 14));
    put16(18, id);
    put16(20, 16'h4000);
    exp_frame[22] = 8'h40;
    exp_frame[23] = t[7:0];
    put16(24, 16'h0000);
    put16(26, t[103:88]);
    put16(28, t[87:72]);
    put16(30, t[71:56]);
    put16(32, t[55:40]);
    put16(34, t[39:24]);
    put16(36, t[23:8]);
    put16(38, 16'(clen - 34));
    put16(40, 16'h0000);
    for (int k = 42; k < clen; k++) exp_frame[k] = 8'(k);
`ifdef PKT_IP_CSUM_EN
    sum = 32'd0;
    for (int w = 0; w < 10; w++) sum = sum + 32'({exp_frame[14+2*w], exp_frame[15+2*w]});
    while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
    put16(24, ~sum[15:0]);
`endif
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [7:0]  cur_bytes[$];
  int          cur_beats = 0;
  int          frames_done = 0;
  int          first_cyc_q[$];
  int          tlast_cyc_q[$];
  int          exp_pkts = 0;
  logic [47:0] exp_bytes = '0;
  int          got_len = 0;
  int          got_beats = 0;
  logic [7:0]  got_keep = '0;
  logic        hold_pend = 1'b0;
  logic [72:0] hold_beat = '0;
  logic        bp_mode = 1'b0;

  task automatic check_frame(input logic [7:0] lk, input logic [63:0] ld);
    logic [119:0] d;
    logic [63:0]  pad;
    logic [7:0]   keep_exp;
    int clen, bad;
    got_len   = cur_bytes.size();
    got_beats = cur_beats;
    got_keep  = lk;
    for (int k = 0; k < got_len && k < 1514; k++) got_frame[k] = cur_bytes[k];
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL frame_unexpected: got a frame of %0d bytes, expected none", got_len);
    end else begin
      d = sb_q.pop_front();
      build_expected(d, exp_pkts[15:0], clen);
      check("frame_len", got_len, clen);
      check("frame_beats", got_beats, (clen + 7) / 8);
      keep_exp = (clen % 8 == 0) ? 8'hFF : 8'((1 << (clen % 8)) - 1);
      check("last_keep", lk, keep_exp);
      pad = ld;
      for (int i = 0; i < 8; i++) if (lk[i]) pad[8*i +: 8] = 8'h00;
      check("last_pad", pad, 64'h0);
      bad = -1;
      for (int k = 0; k < clen && k < got_len; k++)
        if (bad < 0 && cur_bytes[k] !== exp_frame[k]) bad = k;
      tests++;
      if (bad >= 0) begin
        fails++;
        $display("FAIL frame_bytes: offset %0d got 0x%0h, expected 0x%0h",
                 bad, cur_bytes[bad], exp_frame[bad]);
      end
      exp_pkts++;
      exp_bytes = exp_bytes + 48'(clen);
    end
    frames_done++;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      cur_bytes.delete();
      cur_beats = 0;
      sb_q.delete();
      exp_pkts  = 0;
      exp_bytes = '0;
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("stall_valid", axis.tvalid, 1'b1);
        check("stall_hold", {axis.tdata, axis.tkeep, axis.tlast}, hold_beat);
      end
      hold_pend = axis.tvalid && !axis.tready;
      hold_beat = {axis.tdata, axis.tkeep, axis.tlast};
      if (axis.tvalid && axis.tready) begin
        if (cur_beats == 0) first_cyc_q.push_back(cyc);
        for (int i = 0; i < 8; i++)
          if (axis.tkeep[i]) cur_bytes.push_back(axis.tdata[8*i +: 8]);
        cur_beats++;
        if (axis.tlast) begin
          tlast_cyc_q.push_back(cyc);
          check_frame(axis.tkeep, axis.tdata);
          cur_bytes.delete();
          cur_beats = 0;
        end else begin
          check("mid_keep", axis.tkeep, 8'hFF);
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (bp_mode) axis.tready = 1'($urandom_range(0, 1));
  end

  task automatic wait_frames(input int target, input int budget, input string name);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (frames_done < target) begin
      fails++;
      $display("FAIL %s: timeout, got %0d frames, expected %0d", name, frames_done, target);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] len_in;
    int          exp_len;
    int          exp_beats;
    logic [7:0]  exp_keep;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int base_f, base_l, base_r, p0, f0, n, fr_before;

    vecs[0] = '{16'd20,   60,   8,   8'h0F};
    vecs[1] = '{16'd2000, 1514, 190, 8'h03};
    vecs[2] = '{16'd0,    60,   8,   8'h0F};
    vecs[3] = '{16'd61,   61,   8,   8'h1F};
    vecs[4] = '{16'd1514, 1514, 190, 8'h03};
    vecs[5] = '{16'd100,  100,  13,  8'h0F};
    vecs[6] = '{16'd1515, 1514, 190, 8'h03};
    vecs[7] = '{16'd59,   60,   8,   8'h0F};

    // Reset held with a descriptor waiting: nothing may move.
    axis.tready = 1'b1;
    gen_en = 1'b1;
    push_desc({32'h0A00_0001, 32'h0A00_0002, 16'd1000, 16'd2000, 8'd17}, 16'd64);
    repeat (5) begin
      @(negedge clk);
      check("reset_outputs", {fifo_rd_en, axis.tvalid, axis.tlast, axis.tkeep, axis.tdata}, '0);
      check("reset_counters", {pkt_count, byte_count}, '0);
    end
    tick();
    reset = 1'b0;

    // Basic 64-byte UDP frame.
    wait_frames(1, 100, "basic_frame");
    tick();
    check("basic_ethertype", {got_frame[12], got_frame[13]}, 16'h0800);
    check("basic_dst_mac_lsb", got_frame[5], 8'h02);
    check("basic_tot_len", {got_frame[16], got_frame[17]}, 16'h0032);
    check("basic_l4_len", {got_frame[38], got_frame[39]}, 16'h001E);
    check("basic_byte42", got_frame[42], 8'h2A);
    check("basic_beats", got_beats, 8);
    check("basic_last_keep", got_keep, 8'hFF);
`ifndef PKT_IP_CSUM_EN
    check("basic_csum", {got_frame[24], got_frame[25]}, 16'h0000);
`endif
    check("basic_pkt_count", pkt_count, 32'd1);
    check("basic_byte_count", byte_count, 48'd64);
    check("basic_latency", first_cyc_q[0] - rd_cyc_q[0], 2);

    // Directed length/clamp table.
    for (int i = 0; i < 8; i++) begin
      push_desc(rand_tuple(), vecs[i].len_in);
      wait_frames(frames_done + 1, 400, "table_frame");
      tick();
      check("table_len", got_len, vecs[i].exp_len);
      check("table_beats", got_beats, vecs[i].exp_beats);
      check("table_last_keep", got_keep, vecs[i].exp_keep);
      check("table_pkt_count", pkt_count, 32'(exp_pkts));
      check("table_byte_count", byte_count, exp_bytes);
    end

    // Random descriptors under random backpressure.
    bp_mode = 1'b1;
    n = frames_done + 12;
    for (int i = 0; i < 12; i++) push_desc(rand_tuple(), 16'($urandom_range(0, 1600)));
    wait_frames(n, 20000, "bp_frames");
    bp_mode = 1'b0;
    tick();
    axis.tready = 1'b1;
    check("bp_pkt_count", pkt_count, 32'(exp_pkts));
    check("bp_byte_count", byte_count, exp_bytes);

    // Three queued frames: gap from tlast to next tvalid, pop-to-tvalid latency.
    tick();
    base_f = first_cyc_q.size();
    base_l = tlast_cyc_q.size();
    base_r = rd_cyc_q.size();
    push_desc(rand_tuple(), 16'd64);
    push_desc(rand_tuple(), 16'd100);
    push_desc(rand_tuple(), 16'd60);
    wait_frames(frames_done + 3, 500, "gap_frames");
    for (int j = 0; j < 2; j++)
      check("ifg_gap", first_cyc_q[base_f+j+1] - tlast_cyc_q[base_l+j], IFG + 3);
    for (int j = 0; j < 3; j++)
      check("pop_to_tvalid", first_cyc_q[base_f+j] - rd_cyc_q[base_r+j], 2);

    // gen_en dropped mid-frame: frame completes, no further pop.
    tick();
    p0 = pops;
    f0 = frames_done;
    push_desc(rand_tuple(), 16'd300);
    push_desc(rand_tuple(), 16'd60);
    n = 0;
    while (!axis.tvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("gen_off_started", axis.tvalid, 1'b1);
    tick();
    gen_en = 1'b0;
    wait_frames(f0 + 1, 200, "gen_off_frame");
    repeat (30) tick();
    check("gen_off_frames", frames_done, f0 + 1);
    check("gen_off_pops", pops, p0 + 1);
    check("gen_off_fifo", desc_q.size(), 1);
    gen_en = 1'b1;
    wait_frames(f0 + 2, 100, "gen_on_frame");

    // Reset in the middle of a frame.
    tick();
    push_desc(rand_tuple(), 16'd200);
    n = 0;
    while (cur_beats < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("midrst_reached_beat3", cur_beats >= 3, 1'b1);
    #1;
    reset = 1'b1;
    fr_before = frames_done;
    push_desc(rand_tuple(), 16'd64);
    tick();
    check("midrst_tvalid", axis.tvalid, 1'b0);
    check("midrst_tlast", axis.tlast, 1'b0);
    check("midrst_counters", {pkt_count, byte_count}, '0);
    repeat (3) begin
      @(negedge clk);
      check("midrst_no_pop", fifo_rd_en, 1'b0);
    end
    tick();
    reset = 1'b0;
    check("midrst_no_tlast", frames_done, fr_before);
    wait_frames(fr_before + 1, 100, "post_reset_frame");
    tick();
    check("post_reset_pkt_count", pkt_count, 32'd1);
    check("post_reset_byte_count", byte_count, 48'd64);
    check("post_reset_ip_id", {got_frame[18], got_frame[19]}, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
